dcp_fogging: RTL and testbench
==============================

# dcp_fogging

Pipelined haze synthesizer: the inverse of the DCP defogging stage. Per pixel it computes I = (J·t + A·(255 − t)) / 255 for each RGB channel, from a clean pixel J, an 8-bit transmittance t and an 8-bit atmospheric light A. It uses the same 24-bit RGB / 8-bit transmittance / 8-bit atmospheric-light conventions as the defogging stage. It produces hazy reference frames that feed the defogging datapath for closed-loop verification and demo streams.

## Interface
Parameters:
- A_LATCH_ON_SOF, default 1: 1 = atmospheric light is sampled once per frame, on the start-of-frame pixel; 0 = sampled on every valid pixel.

Ports:
- pixelclk  in  1  sole clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- i_rgb  in  24  clean pixel J: [23:16] R, [15:8] G, [7:0] B.
- i_transmittance  in  8  t; 255 means fully transparent, 0 means fully hazy.
- i_dark_max  in  8  atmospheric light A.
- i_frame_start  in  1  marks the first pixel of a frame; qualified by i_data_valid.
- i_data_valid  in  1  input pixel qualifier.
- o_fogged  out  24  hazy pixel I, same channel order as i_rgb.
- o_data_valid  out  1  output qualifier.

## Operation
- Reset: o_fogged = 24'h000000, o_data_valid = 0, latched A = 8'd255, all pipeline valids = 0.
- The pipeline has no backpressure. Each valid input produces exactly one valid output, in order. Invalid cycles are bubbles that propagate.
- Atmospheric-light register A_r:
  - A_LATCH_ON_SOF = 1: A_r loads i_dark_max when i_data_valid && i_frame_start. The SOF pixel itself uses the new value, bypassed in the same cycle. A_r holds otherwise.
  - A_LATCH_ON_SOF = 0: the pixel uses i_dark_max directly.
- Stage 1 (register): capture J channels, t, tc = 255 − t (8-bit), the effective A, and the valid bit.
- Stage 2 (multiply): per channel, p = J·t (16 bit) and q = A·tc (16 bit).
- Stage 3 (sum/divide): x = p + q (17-bit datapath; max value 65025).
  - Division by 255 with rounding: y = (x + 128 + ((x + 128) >> 8)) >> 8.
  - This equals round(x/255) for all x ≤ 65025, and y ≤ 255. No saturation is needed, but y is truncated to 8 bits.
- Output register: o_fogged loads {yR, yG, yB} only when stage-3 valid = 1, and holds its last value otherwise. o_data_valid equals stage-3 valid.
- Boundary values:
  - t = 255 → I = J exactly.
  - t = 0 → I = {A, A, A} exactly.
  - J = A on all channels → I = J for any t.
- Pipeline data registers need not be cleared on reset. The valid bits and the outputs must be.

## Timing
- Latency: a valid input at rising edge n appears on o_fogged / o_data_valid after edge n+3. Throughput is one pixel per clock.
- o_data_valid pattern = i_data_valid pattern delayed by exactly 3 cycles, bubbles included.
- A_r update is visible to the SOF pixel itself and to all later pixels. Pixels already in flight keep the A they captured.
- Reset asserted mid-stream: on the next edge all in-flight pixels are discarded, o_data_valid = 0, o_fogged = 0, and A_r = 255. The first valid pixel after reset deasserts emerges 3 cycles later.
- Simultaneous i_frame_start and !i_data_valid: ignored, A_r is unchanged.

## Test plan
- Identity: t = 255, A = 100, J = 24'h123456, valid for 1 cycle → o_fogged = 24'h123456 with o_data_valid high for exactly 1 cycle, 3 cycles later.
- Full haze: t = 0, SOF pixel with i_dark_max = 200, J = 24'hFFFFFF → o_fogged = 24'hC8C8C8.
- Rounding: t = 128, A = 255, J = 24'h000000 → 24'h7F7F7F. Then t = 1, A = 255, J = 24'hFF00FF → 24'hFFFEFF. Then a random sweep compared against a round(x/255) reference model, 10k pixels.
- SOF latching (A_LATCH_ON_SOF = 1): SOF with A = 50, then non-SOF pixels with i_dark_max = 250 and t = 0 → all outputs 24'h323232. Next SOF with A = 250 → 24'hFAFAFA from that pixel onward.
- Bubbles: valid pattern 1,0,1,1,0,0,1 → identical o_data_valid pattern 3 cycles later. o_fogged holds its value during the 0s.
- Reset mid-stream: assert reset for 1 cycle while 3 pixels are in flight → none emerge, outputs = 0, A_r = 255. The next t = 0 non-SOF pixel yields 24'hFFFFFF.

Source files
------------

// File: rtl/dcp_fogging.sv
// dcp_fogging: per-channel haze synthesis I = (J*t + A*(255-t)) / 255, rounded, 4-stage pipeline.
module dcp_fogging #(
    parameter bit A_LATCH_ON_SOF = 1'b1
) (
    input  logic        pixelclk,
    input  logic        reset,
    input  logic [23:0] i_rgb,
    input  logic [7:0]  i_transmittance,
    input  logic [7:0]  i_dark_max,
    input  logic        i_frame_start,
    input  logic        i_data_valid,
    output logic [23:0] o_fogged,
    output logic        o_data_valid
);

    logic [7:0]  a_r;
    logic [7:0]  a_eff;
    logic [7:0]  s1_j [3];
    logic [7:0]  s1_t, s1_tc, s1_a;
    logic        s1_v;
    logic [15:0] s2_p [3];
    logic [15:0] s2_q [3];
    logic        s2_v;
    logic [16:0] s3_x [3];
    logic        s3_v;
    logic [16:0] w [3];
    logic [7:0]  y [3];

    // the SOF pixel sees its own atmospheric light through the bypass
    assign a_eff = !A_LATCH_ON_SOF ? i_dark_max :
                   (i_data_valid && i_frame_start) ? i_dark_max : a_r;

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            w[c] = s3_x[c] + 17'd128;
            w[c] = w[c] + (w[c] >> 8);
            y[c] = 8'(w[c] >> 8);
        end
    end

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            a_r          <= 8'd255;
            s1_v         <= 1'b0;
            s2_v         <= 1'b0;
            s3_v         <= 1'b0;
            o_data_valid <= 1'b0;
            o_fogged     <= 24'h000000;
        end else begin
            if (i_data_valid && i_frame_start)
                a_r <= i_dark_max;
            s1_v         <= i_data_valid;
            s2_v         <= s1_v;
            s3_v         <= s2_v;
            o_data_valid <= s3_v;
            if (s3_v)
                o_fogged <= {y[0], y[1], y[2]};
        end
    end

    always_ff @(posedge pixelclk) begin
        s1_t  <= i_transmittance;
        s1_tc <= ~i_transmittance;
        s1_a  <= a_eff;
        for (int c = 0; c < 3; c++) begin
            s1_j[c] <= i_rgb[23-8*c -: 8];
            s2_p[c] <= 16'(s1_j[c]) * 16'(s1_t);
            s2_q[c] <= 16'(s1_a) * 16'(s1_tc);
            s3_x[c] <= 17'(s2_p[c]) + 17'(s2_q[c]);
        end
    end

endmodule

// File: tb/tb_dcp_fogging.sv
// tb_dcp_fogging: directed and randomized checks of the fogging pipeline.
module tb_dcp_fogging;

    logic        pixelclk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] i_rgb = '0;
    logic [7:0]  i_transmittance = '0;
    logic [7:0]  i_dark_max = '0;
    logic        i_frame_start = 1'b0;
    logic        i_data_valid = 1'b0;
    logic [23:0] o_fogged;
    logic        o_data_valid;
    int          n_pass = 0;
    int          n_total = 0;

    dcp_fogging dut (
        .pixelclk(pixelclk),
        .reset(reset),
        .i_rgb(i_rgb),
        .i_transmittance(i_transmittance),
        .i_dark_max(i_dark_max),
        .i_frame_start(i_frame_start),
        .i_data_valid(i_data_valid),
        .o_fogged(o_fogged),
        .o_data_valid(o_data_valid)
    );

    always #5 pixelclk = ~pixelclk;

    task automatic drive(input logic [23:0] j, input logic [7:0] t, input logic [7:0] a,
                         input logic sof, input logic v);
        i_rgb = j;
        i_transmittance = t;
        i_dark_max = a;
        i_frame_start = sof;
        i_data_valid = v;
    endtask

    task automatic tick;
        @(posedge pixelclk);
        #1;
    endtask

    function automatic logic [7:0] ref_ch(input int j, input int t, input int a);
        return 8'(((j * t + a * (255 - t)) * 2 + 255) / 510);
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        drive(24'h0, 8'd0, 8'd0, 1'b0, 1'b0);
        tick();
        tick();
        n_total++;
        if (o_fogged !== 24'h000000) $display("FAIL reset_fogged got %h want 000000", o_fogged);
        else n_pass++;
        n_total++;
        if (o_data_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_data_valid);
        else n_pass++;
        reset = 1'b0;
        drive(24'h000000, 8'd0, 8'd7, 1'b0, 1'b1);
        tick();
        drive(24'h0, 8'd0, 8'd0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        n_total++;
        if (o_data_valid !== 1'b1 || o_fogged !== 24'hFFFFFF)
            $display("FAIL reset_a255 got v=%b %h want v=1 ffffff", o_data_valid, o_fogged);
        else n_pass++;
        tick();
    endtask

    task automatic test_identity;
        drive(24'h123456, 8'd255, 8'd100, 1'b0, 1'b1);
        tick();
        drive(24'h0, 8'd0, 8'd0, 1'b0, 1'b0);
        tick();
        tick();
        n_total++;
        if (o_data_valid !== 1'b0) $display("FAIL identity_early got v=%b want 0", o_data_valid);
        else n_pass++;
        tick();
        n_total++;
        if (o_data_valid !== 1'b1 || o_fogged !== 24'h123456)
            $display("FAIL identity got v=%b %h want v=1 123456", o_data_valid, o_fogged);
        else n_pass++;
        tick();
        n_total++;
        if (o_data_valid !== 1'b0 || o_fogged !== 24'h123456)
            $display("FAIL identity_hold got v=%b %h want v=0 123456", o_data_valid, o_fogged);
        else n_pass++;
    endtask

    task automatic test_full_haze;
        drive(24'hFFFFFF, 8'd0, 8'd200, 1'b1, 1'b1);
        tick();
        drive(24'h0, 8'd0, 8'd0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        n_total++;
        if (o_data_valid !== 1'b1 || o_fogged !== 24'hC8C8C8)
            $display("FAIL full_haze got v=%b %h want v=1 c8c8c8", o_data_valid, o_fogged);
        else n_pass++;
        tick();
    endtask

    task automatic test_rounding;
        drive(24'h000000, 8'd128, 8'd255, 1'b1, 1'b1);
        tick();
        drive(24'hFF00FF, 8'd1, 8'd255, 1'b0, 1'b1);
        tick();
        drive(24'h0, 8'd0, 8'd0, 1'b0, 1'b0);
        tick();
        tick();
        n_total++;
        if (o_data_valid !== 1'b1 || o_fogged !== 24'h7F7F7F)
            $display("FAIL round_half got v=%b %h want v=1 7f7f7f", o_data_valid, o_fogged);
        else n_pass++;
        tick();
        n_total++;
        if (o_data_valid !== 1'b1 || o_fogged !== 24'hFFFEFF)
            $display("FAIL round_t1 got v=%b %h want v=1 fffeff", o_data_valid, o_fogged);
        else n_pass++;
        tick();
        tick();
    endtask

    task automatic test_sweep;
        logic [23:0] eq[$];
        bit          vq[$];
        int          a_m = 0;
        int          errs = 0;
        vq = '{1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10003; i++) begin
            logic [23:0] j;
            logic [7:0]  t, a;
            logic        v, sof, ev;
            j = 24'($urandom);
            t = 8'($urandom);
            a = 8'($urandom);
            v = (i == 0) || ($urandom_range(0, 3) != 0);
            sof = (i == 0) || ($urandom_range(0, 31) == 0);
            if (i >= 10000) v = 1'b0;
            if (v && sof) a_m = a;
            if (v) eq.push_back({ref_ch(j[23:16], t, a_m), ref_ch(j[15:8], t, a_m), ref_ch(j[7:0], t, a_m)});
            drive(j, t, a, sof, v);
            vq.push_back(v);
            tick();
            ev = vq.pop_front();
            n_total++;
            if (o_data_valid !== ev) begin
                if (errs++ < 10) $display("FAIL sweep_valid i=%0d got %b want %b", i, o_data_valid, ev);
            end else n_pass++;
            if (ev && eq.size() > 0) begin
                logic [23:0] e;
                e = eq.pop_front();
                n_total++;
                if (o_fogged !== e) begin
                    if (errs++ < 10) $display("FAIL sweep_pixel i=%0d got %h want %h", i, o_fogged, e);
                end else n_pass++;
            end
        end
        n_total++;
        if (eq.size() != 0) $display("FAIL sweep_drain got %0d left want 0", eq.size());
        else n_pass++;
    endtask

    task automatic test_sof_latch;
        logic        vv [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        sf [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0]  dk [6] = '{8'd50, 8'd250, 8'd99, 8'd250, 8'd250, 8'd10};
        logic [23:0] jj [6] = '{24'h123456, 24'hABCDEF, 24'h0, 24'hFFFFFF, 24'h000000, 24'h777777};
        logic [23:0] ex [6] = '{24'h323232, 24'h323232, 24'h323232, 24'h323232, 24'hFAFAFA, 24'hFAFAFA};
        for (int k = 0; k < 9; k++) begin
            if (k < 6) drive(jj[k], 8'd0, dk[k], sf[k], vv[k]);
            else drive(24'h0, 8'd0, 8'd0, 1'b0, 1'b0);
            tick();
            if (k >= 3) begin
                n_total++;
                if (o_data_valid !== vv[k-3] || o_fogged !== ex[k-3])
                    $display("FAIL sof_latch row=%0d got v=%b %h want v=%b %h",
                             k - 3, o_data_valid, o_fogged, vv[k-3], ex[k-3]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_bubbles;
        logic        vv [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [23:0] jj [7] = '{24'h111111, 24'hDEAD00, 24'h222222, 24'h333333, 24'hDEAD01, 24'hDEAD02, 24'h444444};
        logic [23:0] ex [7] = '{24'h111111, 24'h111111, 24'h222222, 24'h333333, 24'h333333, 24'h333333, 24'h444444};
        for (int k = 0; k < 10; k++) begin
            if (k < 7) drive(jj[k], 8'd255, 8'd0, 1'b0, vv[k]);
            else drive(24'h0, 8'd0, 8'd0, 1'b0, 1'b0);
            tick();
            if (k >= 3) begin
                n_total++;
                if (o_data_valid !== vv[k-3] || o_fogged !== ex[k-3])
                    $display("FAIL bubbles row=%0d got v=%b %h want v=%b %h",
                             k - 3, o_data_valid, o_fogged, vv[k-3], ex[k-3]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid;
        drive(24'hABCDEF, 8'd255, 8'd9, 1'b1, 1'b1);
        tick();
        drive(24'h135790, 8'd255, 8'd9, 1'b0, 1'b1);
        tick();
        drive(24'h246802, 8'd255, 8'd9, 1'b0, 1'b1);
        tick();
        reset = 1'b1;
        drive(24'h0, 8'd0, 8'd0, 1'b0, 1'b0);
        tick();
        n_total++;
        if (o_data_valid !== 1'b0 || o_fogged !== 24'h000000)
            $display("FAIL reset_mid got v=%b %h want v=0 000000", o_data_valid, o_fogged);
        else n_pass++;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++;
            if (o_data_valid !== 1'b0 || o_fogged !== 24'h000000)
                $display("FAIL reset_flush k=%0d got v=%b %h want v=0 000000", k, o_data_valid, o_fogged);
            else n_pass++;
        end
        drive(24'h000000, 8'd0, 8'd5, 1'b0, 1'b1);
        tick();
        drive(24'h0, 8'd0, 8'd0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        n_total++;
        if (o_data_valid !== 1'b1 || o_fogged !== 24'hFFFFFF)
            $display("FAIL reset_mid_a got v=%b %h want v=1 ffffff", o_data_valid, o_fogged);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_full_haze();
        test_rounding();
        test_sof_latch();
        test_bubbles();
        test_sweep();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
